// File: rtl/qspi_sram_responder_pkg.sv
// Shared opcodes, framing constants and FSM state type for the QSPI SRAM responder.
package qspi_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  localparam int ADDR_BYTES   = 3;
  localparam int ADDR_NIBBLES = ADDR_BYTES * 2;
  localparam int CMD_NIBBLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_DUMMY,
    ST_RDATA,
    ST_IGNORE
  } qspi_state_e;

endpackage

// File: rtl/qspi_sram_responder_if.sv
// QSPI bus bundle between the SRAM controller (master) and the responder (slave).
interface qspi_sram_responder_if;

  logic       sclk;
  logic       cs_n;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       active;

  modport master (
    output sclk, cs_n, sio_in,
    input  sio_out, sio_oe, active
  );

  modport slave (
    input  sclk, cs_n, sio_in,
    output sio_out, sio_oe, active
  );

endinterface

// File: rtl/qspi_sram_responder_sync_edge.sv
// SYNC_ST-flop synchronizer with single-clk rise/fall pulses on the synchronized level.
module qspi_sync_edge #(
  parameter int SYNC_ST   = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_ST-1:0] pipe;
  logic               prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= {SYNC_ST{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < SYNC_ST; i++) begin
        pipe[i] <= pipe[i-1];
      end
      prev <= pipe[SYNC_ST-1];
    end
  end

  assign rise = pipe[SYNC_ST-1] & ~prev;
  assign fall = ~pipe[SYNC_ST-1] & prev;

endmodule

// File: rtl/qspi_sram_responder.sv
// QSPI (SQI) serial-SRAM target: WRITE 0x02 / READ 0x03 into an internal byte array, oversampled on clk.
// Optional QSPI_RESP_STATS_EN adds txn_count and bad_cmd_count outputs.
module qspi_sram_responder
  import qspi_pkg::*;
#(
  parameter int MEM_AW   = 10,
  parameter int DUMMY_CY = 2,
  parameter int SYNC_ST  = 2
) (
  input  logic clk,
  input  logic rst_n,
  qspi_sram_responder_if.slave bus
`ifdef QSPI_RESP_STATS_EN
  ,
  output logic [15:0] txn_count,
  output logic [7:0]  bad_cmd_count
`endif
);

  localparam int          SHIFT_W    = (ADDR_NIBBLES - 1) * 4;
  localparam logic [3:0]  DUMMY_LAST = 4'(DUMMY_CY);
  localparam logic [2:0]  CMD_LAST   = 3'(CMD_NIBBLES - 1);
  localparam logic [2:0]  ADDR_LAST  = 3'(ADDR_NIBBLES - 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  qspi_sync_edge #(.SYNC_ST(SYNC_ST), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  qspi_sync_edge #(.SYNC_ST(SYNC_ST), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Data pins get the same flop depth as sclk so a rise pulse lines up with the nibble it sampled.
  logic [SYNC_ST-1:0][3:0] sio_pipe;
  logic [3:0]              sio_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sio_pipe <= '0;
    end else begin
      sio_pipe[0] <= bus.sio_in;
      for (int i = 1; i < SYNC_ST; i++) begin
        sio_pipe[i] <= sio_pipe[i-1];
      end
    end
  end

  assign sio_s = sio_pipe[SYNC_ST-1];

  qspi_state_e         state;
  logic [2:0]          nib_cnt;
  logic [3:0]          dummy_cnt;
  logic [SHIFT_W-1:0]  shift_reg;
  logic                is_read;
  logic [MEM_AW-1:0]   addr;
  logic [MEM_AW-1:0]   addr_inc;
  logic [3:0]          hi_nib;
  logic [7:0]          rd_byte;
  logic [7:0]          mem [2**MEM_AW];
  logic                mem_we;

  assign addr_inc = addr + MEM_AW'(1);
  assign mem_we   = (state == ST_WDATA) && sclk_rise && !cs_rise && (nib_cnt == 3'd1);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= {hi_nib, sio_s};
    end
  end

  // cs_n rise aborts any state; an unfinished write byte lives only in hi_nib and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      nib_cnt     <= '0;
      dummy_cnt   <= '0;
      shift_reg   <= '0;
      is_read     <= 1'b0;
      addr        <= '0;
      hi_nib      <= '0;
      rd_byte     <= '0;
      bus.sio_out <= '0;
      bus.sio_oe  <= 1'b0;
      bus.active  <= 1'b0;
`ifdef QSPI_RESP_STATS_EN
      txn_count     <= '0;
      bad_cmd_count <= '0;
`endif
    end else if (cs_rise) begin
`ifdef QSPI_RESP_STATS_EN
      if ((state == ST_WDATA || state == ST_RDATA) && txn_count != 16'hFFFF) begin
        txn_count <= txn_count + 16'd1;
      end
`endif
      state       <= ST_IDLE;
      nib_cnt     <= '0;
      dummy_cnt   <= '0;
      bus.sio_out <= '0;
      bus.sio_oe  <= 1'b0;
      bus.active  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state      <= ST_CMD;
            nib_cnt    <= '0;
            bus.active <= 1'b1;
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            shift_reg <= {shift_reg[SHIFT_W-5:0], sio_s};
            if (nib_cnt == CMD_LAST) begin
              nib_cnt <= '0;
              if ({shift_reg[3:0], sio_s} == OP_WRITE) begin
                is_read <= 1'b0;
                state   <= ST_ADDR;
              end else if ({shift_reg[3:0], sio_s} == OP_READ) begin
                is_read <= 1'b1;
                state   <= ST_ADDR;
              end else begin
                state <= ST_IGNORE;
`ifdef QSPI_RESP_STATS_EN
                if (bad_cmd_count != 8'hFF) begin
                  bad_cmd_count <= bad_cmd_count + 8'd1;
                end
`endif
              end
            end else begin
              nib_cnt <= nib_cnt + 3'd1;
            end
          end
        end

        ST_ADDR: begin
          if (sclk_rise) begin
            shift_reg <= {shift_reg[SHIFT_W-5:0], sio_s};
            if (nib_cnt == ADDR_LAST) begin
              nib_cnt <= '0;
              addr    <= MEM_AW'({shift_reg, sio_s});
              if (is_read) begin
                // Prefetch now so the first data nibble is ready on the last dummy falling edge.
                rd_byte   <= mem[MEM_AW'({shift_reg, sio_s})];
                dummy_cnt <= '0;
                state     <= ST_DUMMY;
              end else begin
                state <= ST_WDATA;
              end
            end else begin
              nib_cnt <= nib_cnt + 3'd1;
            end
          end
        end

        ST_WDATA: begin
          if (sclk_rise) begin
            if (nib_cnt == 3'd0) begin
              hi_nib  <= sio_s;
              nib_cnt <= 3'd1;
            end else begin
              nib_cnt <= 3'd0;
              addr    <= addr_inc;
            end
          end
        end

        ST_DUMMY: begin
          if (sclk_fall && dummy_cnt == DUMMY_LAST) begin
            state       <= ST_RDATA;
            bus.sio_oe  <= 1'b1;
            bus.sio_out <= rd_byte[7:4];
            nib_cnt     <= 3'd1;
          end else if (sclk_rise) begin
            dummy_cnt <= dummy_cnt + 4'd1;
          end
        end

        ST_RDATA: begin
          if (sclk_fall) begin
            if (nib_cnt == 3'd1) begin
              bus.sio_out <= rd_byte[3:0];
              nib_cnt     <= 3'd0;
              addr        <= addr_inc;
              rd_byte     <= mem[addr_inc];
            end else begin
              bus.sio_out <= rd_byte[7:4];
              nib_cnt     <= 3'd1;
            end
          end
        end

        ST_IGNORE: begin
          state <= ST_IGNORE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
